// File: rtl/bullet_controller.sv
// ----------------------------------------------------------------------------
// bullet_controller
//   Sequences one player's projectile. A fire request sampled on a frame tick
//   launches the bullet from the ship position. The bullet then steps STEP
//   pixels per frame along the launch direction. It retires when it strikes
//   the target or when its next move would leave the screen. After a retire,
//   a cooldown of COOLDOWN_FRAMES ticks must pass before the next shot.
//
// Ports
//   Clk          in   1   system clock
//   Reset_n      in   1   asynchronous, active-low reset
//   frame_clk    in   1   frame strobe, asynchronous to Clk
//   fire         in   1   level fire request, sampled on frame ticks only
//   dir          in   2   launch direction: 00 up, 01 right, 10 down, 11 left
//   ShipX/ShipY  in   10  ship centre, latched at launch
//   TargetX/Y    in   10  opponent centre
//   Target_size  in   10  opponent half-width
//   BulletX/Y    out  10  bullet centre
//   bullet_on    out  1   bullet is live and should be drawn
//   fire_ack     out  1   one-Clk pulse: shot launched
//   hit          out  1   one-Clk pulse: bullet struck the target
// ----------------------------------------------------------------------------
module bullet_controller #(
    parameter int X_MAX           = 639,
    parameter int Y_MAX           = 479,
    parameter int STEP            = 4,
    parameter int BULLET_SIZE     = 4,
    parameter int COOLDOWN_FRAMES = 15
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       fire,
    input  logic [1:0] dir,
    input  logic [9:0] ShipX,
    input  logic [9:0] ShipY,
    input  logic [9:0] TargetX,
    input  logic [9:0] TargetY,
    input  logic [9:0] Target_size,
    output logic [9:0] BulletX,
    output logic [9:0] BulletY,
    output logic       bullet_on,
    output logic       fire_ack,
    output logic       hit
);

    localparam int CW = $clog2(COOLDOWN_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FLY      = 2'd1,
        COOLDOWN = 2'd2
    } state_t;

    state_t         state_reg, state_next;
    logic [9:0]     x_reg, x_next;
    logic [9:0]     y_reg, y_next;
    logic [1:0]     dir_reg, dir_next;
    logic           on_reg, on_next;
    logic           ack_reg, ack_next;
    logic           hit_reg, hit_next;
    logic [CW-1:0]  count_reg, count_next;

    // Frame strobe synchronizer plus edge detector.
    logic sync1_reg, sync2_reg, prev_reg;
    logic tick;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= frame_clk;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign tick = sync2_reg & ~prev_reg;

    // Hit window, evaluated on the pre-move position. Differences are
    // taken in 11-bit signed so screen coordinates cannot wrap.
    logic signed [10:0] dx, dy;
    logic        [10:0] adx, ady, reach;
    logic               hit_now;

    always_comb begin
        dx      = $signed({1'b0, x_reg}) - $signed({1'b0, TargetX});
        dy      = $signed({1'b0, y_reg}) - $signed({1'b0, TargetY});
        adx     = dx[10] ? 11'(-dx) : 11'(dx);
        ady     = dy[10] ? 11'(-dy) : 11'(dy);
        reach   = {1'b0, Target_size} + 11'(BULLET_SIZE);
        hit_now = (adx <= reach) && (ady <= reach);
    end

    // Screen-exit test for the pending move, widened to 11 bits.
    logic exit_now;

    always_comb begin
        exit_now = 1'b0;
        case (dir_reg)
            2'b00:   exit_now = {1'b0, y_reg} < 11'(STEP);
            2'b01:   exit_now = ({1'b0, x_reg} + 11'(STEP)) > 11'(X_MAX);
            2'b10:   exit_now = ({1'b0, y_reg} + 11'(STEP)) > 11'(Y_MAX);
            default: exit_now = {1'b0, x_reg} < 11'(STEP);
        endcase
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            dir_reg   <= '0;
            on_reg    <= 1'b0;
            ack_reg   <= 1'b0;
            hit_reg   <= 1'b0;
            count_reg <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            dir_reg   <= dir_next;
            on_reg    <= on_next;
            ack_reg   <= ack_next;
            hit_reg   <= hit_next;
            count_reg <= count_next;
        end
    end

    // Next-state logic. Everything holds between ticks; the two pulses
    // default low so they last exactly one Clk.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        dir_next   = dir_reg;
        on_next    = on_reg;
        ack_next   = 1'b0;
        hit_next   = 1'b0;
        count_next = count_reg;

        if (tick) begin
            case (state_reg)
                IDLE: begin
                    if (fire) begin
                        x_next     = ShipX;
                        y_next     = ShipY;
                        dir_next   = dir;
                        on_next    = 1'b1;
                        ack_next   = 1'b1;
                        state_next = FLY;
                    end
                end

                FLY: begin
                    if (hit_now) begin
                        hit_next   = 1'b1;
                        on_next    = 1'b0;
                        count_next = CW'(COOLDOWN_FRAMES);
                        state_next = COOLDOWN;
                    end else if (exit_now) begin
                        on_next    = 1'b0;
                        count_next = CW'(COOLDOWN_FRAMES);
                        state_next = COOLDOWN;
                    end else begin
                        case (dir_reg)
                            2'b00:   y_next = y_reg - 10'(STEP);
                            2'b01:   x_next = x_reg + 10'(STEP);
                            2'b10:   y_next = y_reg + 10'(STEP);
                            default: x_next = x_reg - 10'(STEP);
                        endcase
                    end
                end

                COOLDOWN: begin
                    // fire is not queued: the count only runs down here.
                    if (count_reg == CW'(1)) begin
                        state_next = IDLE;
                    end
                    count_next = count_reg - CW'(1);
                end

                default: begin
                    state_next = IDLE;
                    on_next    = 1'b0;
                end
            endcase
        end
    end

    assign BulletX   = x_reg;
    assign BulletY   = y_reg;
    assign bullet_on = on_reg;
    assign fire_ack  = ack_reg;
    assign hit       = hit_reg;

endmodule
